// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the multicycle MIPS control path.
//   - Opcode constants decoded by the main control FSM.
//   - ALU_OP codes (also consumed by the ALU control decoder).
//   - 4-bit state encodings, visible on the debug STATE output.
package mips_ctrl_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SW    = 2'b01;
    localparam logic [1:0] ALUOP_LW    = 2'b10;
    localparam logic [1:0] ALUOP_BEQ   = 2'b11;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StWbMem    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StWbR      = 4'd8,
        StBranch   = 4'd9,
        StTrap     = 4'd10
    } ctrl_state_e;

    // States that hold a memory request open and are guarded by the timeout counter.
    function automatic logic is_mem_wait(input ctrl_state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/ctrl_mem_timeout.sv
// Memory wait-cycle counter for the multicycle control FSM.
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset (count = 0)
//   i_clr       synchronous clear (priority over i_en)
//   i_en        count one wait cycle
//   o_expired   count has reached MEM_TIMEOUT
module ctrl_mem_timeout #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    // The FSM leaves the wait state on expiry, so the count never wraps.
    assign o_expired = (r_count == TO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_opcode[5:0]         instruction[31:26], stable from DECODE until next FETCH
//   i_zero                ALU zero flag (branch decision)
//   i_mem_ready           memory completes the current request this cycle
//   o_alu_op[1:0]         00 R-type, 01 SW, 10 LW, 11 BEQ
//   o_alu_src_b           0 = register B, 1 = sign-extended immediate
//   o_mem_req, o_mem_we   memory request / write qualifier
//   o_iord                0 = address from PC, 1 = from ALUOut
//   o_ir_write, o_pc_write, o_pc_src   IR/PC load controls, PC source select
//   o_reg_write, o_reg_dst, o_mem_to_reg   register file write controls
//   o_illegal, o_timeout  sticky trap causes
//   o_state[3:0]          current state for debug
module mips_multicycle_control
    import mips_ctrl_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic [1:0] o_alu_op,
    output logic       o_alu_src_b,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_src,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_illegal,
    output logic       o_timeout,
    output logic [3:0] o_state
);

    ctrl_state_e r_state, w_state_next;
    logic        r_illegal, r_timeout;
    logic        w_set_illegal, w_set_timeout;
    logic        w_to_clr, w_to_en, w_expired;

    // Counter restarts whenever a memory wait state is freshly entered.
    assign w_to_clr = is_mem_wait(w_state_next) && (w_state_next != r_state);
    assign w_to_en  = is_mem_wait(r_state) && !i_mem_ready;

    ctrl_mem_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_to_clr),
        .i_en      (w_to_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
        end
    end

    // Next state. In memory states a ready in the expiry cycle wins over the trap.
    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        unique case (r_state)
            StIdle:   w_state_next = StFetch;
            StFetch: begin
                if (i_mem_ready) begin
                    w_state_next = StDecode;
                end else if (w_expired) begin
                    w_state_next  = StTrap;
                    w_set_timeout = 1'b1;
                end
            end
            StDecode: begin
                unique case (i_opcode)
                    OP_RTYPE:     w_state_next = StExecR;
                    OP_LW, OP_SW: w_state_next = StMemAddr;
                    OP_BEQ:       w_state_next = StBranch;
                    default: begin
                        w_state_next  = StTrap;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            StMemAddr: w_state_next = (i_opcode == OP_LW) ? StMemRead : StMemWrite;
            StMemRead, StMemWrite: begin
                if (i_mem_ready) begin
                    w_state_next = (r_state == StMemRead) ? StWbMem : StFetch;
                end else if (w_expired) begin
                    w_state_next  = StTrap;
                    w_set_timeout = 1'b1;
                end
            end
            StWbMem:  w_state_next = StFetch;
            StExecR:  w_state_next = StWbR;
            StWbR:    w_state_next = StFetch;
            StBranch: w_state_next = StFetch;
            StTrap:   w_state_next = StTrap;
            default:  w_state_next = StIdle;
        endcase
    end

    // Moore decode of the state register; FETCH and BRANCH PC/IR loads are Mealy.
    always_comb begin
        o_alu_op     = ALUOP_RTYPE;
        o_alu_src_b  = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        unique case (r_state)
            StFetch: begin
                o_mem_req  = 1'b1;
                o_ir_write = i_mem_ready;
                o_pc_write = i_mem_ready;
            end
            StMemAddr: begin
                o_alu_src_b = 1'b1;
                o_alu_op    = (i_opcode == OP_LW) ? ALUOP_LW : ALUOP_SW;
            end
            StMemRead: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                o_alu_op  = ALUOP_LW;
            end
            StWbMem: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_iord    = 1'b1;
                o_alu_op  = ALUOP_SW;
            end
            StWbR: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            StBranch: begin
                o_alu_op   = ALUOP_BEQ;
                o_pc_src   = 1'b1;
                o_pc_write = i_zero;
            end
            default: ;
        endcase
    end

    assign o_illegal = r_illegal;
    assign o_timeout = r_timeout;
    assign o_state   = r_state;

endmodule
